// File: rtl/sound_pkg.sv
// Shared source IDs, state encoding and counter widths for the game sound sequencer.
package sound_pkg;

  localparam logic [1:0] SND_NONE = 2'd0;
  localparam logic [1:0] SND_HIT  = 2'd1;
  localparam logic [1:0] SND_MISS = 2'd2;
  localparam logic [1:0] SND_OVER = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int unsigned PRE_W  = 17;
  localparam int unsigned HALF_W = 18;
  localparam int unsigned DUR_W  = 10;

  // Highest-priority source in {over, miss, hit}; over beats miss beats hit.
  function automatic logic [1:0] top_source(input logic [2:0] eff);
    logic [1:0] id;
    id = SND_NONE;
    if (eff[2])      id = SND_OVER;
    else if (eff[1]) id = SND_MISS;
    else if (eff[0]) id = SND_HIT;
    return id;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles wave every `half` enabled cycles; clr restarts it low.
module tone_gen
  import sound_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  output logic              wave
);

  logic [HALF_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en) begin
      if (cnt == half - HALF_W'(1)) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + HALF_W'(1);
      end
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates hit/miss/over sound requests onto the speaker pin: fixed-priority grant,
// timed square tone, silent gap; over preempts hit/miss and ends the rally.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned HIT_MS    = 50,
  parameter int unsigned MISS_MS   = 300,
  parameter int unsigned OVER_MS   = 1000,
  parameter int unsigned GAP_MS    = 20,
  parameter int unsigned HIT_HALF  = 50000,
  parameter int unsigned MISS_HALF = 200000,
  parameter int unsigned OVER_HALF = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit_req,
  input  logic       miss_req,
  input  logic       over_req,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] active_id
);

  if (HIT_MS > 1023 || MISS_MS > 1023 || OVER_MS > 1023 || GAP_MS > 1023 ||
      HIT_MS == 0 || MISS_MS == 0 || OVER_MS == 0 || GAP_MS == 0) begin : g_dur_check
    $error("sound_sequencer: every *_MS must be in 1..1023");
  end
  if (TICK_DIV == 0 || TICK_DIV > (1 << PRE_W)) begin : g_tick_check
    $error("sound_sequencer: TICK_DIV out of range for the prescaler");
  end
  if (HIT_HALF == 0 || MISS_HALF == 0 || OVER_HALF == 0 ||
      HIT_HALF > (1 << HALF_W) || MISS_HALF > (1 << HALF_W) ||
      OVER_HALF > (1 << HALF_W)) begin : g_half_check
    $error("sound_sequencer: *_HALF out of range for the half counter");
  end

  logic [1:0]        state, state_nx;
  logic [2:0]        pend, pend_nx;
  logic [2:0]        req, eff;
  logic [1:0]        grant;
  logic [1:0]        id_nx;
  logic              busy_nx;
  logic [PRE_W-1:0]  pre, pre_nx;
  logic [DUR_W-1:0]  dur, dur_nx;
  logic              tick;
  logic              tone_en, tone_clr;
  logic [HALF_W-1:0] half;
  logic              wave;

  function automatic logic [DUR_W-1:0] dur_of(input logic [1:0] id);
    logic [DUR_W-1:0] d;
    case (id)
      SND_HIT:  d = DUR_W'(HIT_MS);
      SND_MISS: d = DUR_W'(MISS_MS);
      default:  d = DUR_W'(OVER_MS);
    endcase
    return d;
  endfunction

  assign req   = {over_req, miss_req, hit_req};
  assign eff   = pend | req;
  assign grant = top_source(eff);
  assign tick  = (pre == PRE_W'(TICK_DIV - 1));

  // Half-period follows the source currently on the speaker.
  always_comb begin
    half = HALF_W'(OVER_HALF);
    case (active_id)
      SND_HIT:  half = HALF_W'(HIT_HALF);
      SND_MISS: half = HALF_W'(MISS_HALF);
      default:  half = HALF_W'(OVER_HALF);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      active_id <= SND_NONE;
      busy      <= 1'b0;
      pre       <= '0;
      dur       <= '0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      active_id <= id_nx;
      busy      <= busy_nx;
      pre       <= pre_nx;
      dur       <= dur_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend | req;
    id_nx    = active_id;
    busy_nx  = busy;
    pre_nx   = pre;
    dur_nx   = dur;
    tone_en  = 1'b0;
    tone_clr = 1'b0;
    case (state)
      IDLE: begin
        if (|eff) begin
          state_nx = PLAY;
          id_nx    = grant;
          busy_nx  = 1'b1;
          dur_nx   = dur_of(grant);
          pre_nx   = '0;
          tone_clr = 1'b1;
          case (grant)
            SND_HIT:  pend_nx[0] = 1'b0;
            SND_MISS: pend_nx[1] = 1'b0;
            default:  pend_nx    = '0;
          endcase
        end
      end
      PLAY: begin
        tone_en = 1'b1;
        if (eff[2] && active_id != SND_OVER) begin
          // Game over cuts the rally sound short and drops whatever was queued behind it.
          id_nx    = SND_OVER;
          dur_nx   = dur_of(SND_OVER);
          pre_nx   = '0;
          tone_clr = 1'b1;
          pend_nx  = '0;
        end else if (tick) begin
          pre_nx = '0;
          if (dur == DUR_W'(1)) begin
            state_nx = GAP;
            id_nx    = SND_NONE;
            dur_nx   = DUR_W'(GAP_MS);
            tone_clr = 1'b1;
          end else begin
            dur_nx = dur - DUR_W'(1);
          end
        end else begin
          pre_nx = pre + PRE_W'(1);
        end
      end
      GAP: begin
        if (tick) begin
          pre_nx = '0;
          if (dur == DUR_W'(1)) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            dur_nx   = '0;
          end else begin
            dur_nx = dur - DUR_W'(1);
          end
        end else begin
          pre_nx = pre + PRE_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        id_nx    = SND_NONE;
        busy_nx  = 1'b0;
        pre_nx   = '0;
        dur_nx   = '0;
      end
    endcase
  end

  tone_gen u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (tone_en),
    .clr   (tone_clr),
    .half  (half),
    .wave  (wave)
  );

  // Mute gates the pin only; sequencing keeps running underneath.
  assign speaker = wave & ~mute;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random requests/mute, all cycles
// compared against a phase/elapsed-time model of the sound rules.
module tb_sound_sequencer;

  localparam int unsigned TICK      = 10;
  localparam int unsigned HIT_MS    = 3;
  localparam int unsigned MISS_MS   = 5;
  localparam int unsigned OVER_MS   = 8;
  localparam int unsigned GAP_MS    = 2;
  localparam int unsigned HIT_HALF  = 2;
  localparam int unsigned MISS_HALF = 3;
  localparam int unsigned OVER_HALF = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       hit_req, miss_req, over_req, mute;
  logic       speaker, busy;
  logic [1:0] active_id;

  int vectors = 0;
  int errors  = 0;

  // Model: phase 0 idle / 1 tone / 2 gap, source id, cycles elapsed in phase, pending set.
  int       ph, src, t;
  bit [3:0] pend;

  sound_sequencer #(
    .TICK_DIV (TICK),     .HIT_MS   (HIT_MS),   .MISS_MS  (MISS_MS),
    .OVER_MS  (OVER_MS),  .GAP_MS   (GAP_MS),   .HIT_HALF (HIT_HALF),
    .MISS_HALF(MISS_HALF), .OVER_HALF(OVER_HALF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hit_req   (hit_req),
    .miss_req  (miss_req),
    .over_req  (over_req),
    .mute      (mute),
    .speaker   (speaker),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  function automatic int tone_len(input int s);
    if (s == 1) return HIT_MS * TICK;
    if (s == 2) return MISS_MS * TICK;
    return OVER_MS * TICK;
  endfunction

  function automatic int half_of(input int s);
    if (s == 1) return HIT_HALF;
    if (s == 2) return MISS_HALF;
    return OVER_HALF;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; src = 0; t = 0; pend = '0;
  endtask

  task automatic model_step(input bit h, input bit m, input bit o);
    bit [3:0] np;
    int g;
    np = pend | {o, m, h, 1'b0};
    case (ph)
      0: if (np[3:1] != 3'b000) begin
        g   = np[3] ? 3 : (np[2] ? 2 : 1);
        ph  = 1; src = g; t = 0;
        np[g] = 1'b0;
        if (g == 3) np = '0;
      end
      1: if (np[3] && src != 3) begin
        src = 3; t = 0; np = '0;
      end else begin
        t++;
        if (t == tone_len(src)) begin ph = 2; src = 0; t = 0; end
      end
      default: begin
        t++;
        if (t == GAP_MS * TICK) begin ph = 0; t = 0; end
      end
    endcase
    pend = np;
  endtask

  task automatic compare_outputs();
    int exp_spk;
    exp_spk = (ph == 1 && ((t / half_of(src)) % 2 == 1) && !mute) ? 1 : 0;
    check("speaker", int'(speaker), exp_spk);
    check("busy", int'(busy), (ph != 0) ? 1 : 0);
    check("active_id", int'(active_id), (ph == 1) ? src : 0);
  endtask

  // One clock: drive at negedge, compare this cycle, then advance the model at posedge.
  task automatic cycle(input bit h, input bit m, input bit o, input bit mu);
    @(negedge clk);
    hit_req = h; miss_req = m; over_req = o; mute = mu;
    #1;
    compare_outputs();
    @(posedge clk);
    model_step(h, m, o);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!(ph == 0 && pend == 4'b0000) && budget < 400) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      budget++;
    end
    check("idle_timeout", budget < 400 ? 1 : 0, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; hit_req = 1'b0; miss_req = 1'b0; over_req = 1'b0; mute = 1'b0;
    model_reset();
    #1;
    check("rst_speaker", int'(speaker), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active_id", int'(active_id), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
    idle_cycles(3);

    // Single hit: busy next cycle, toggles every 2, 30 tone cycles, 20 gap cycles.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("hit_busy_k1", int'(busy), 1);
    check("hit_id_k1", int'(active_id), 1);
    check("hit_spk_k1", int'(speaker), 0);
    idle_cycles(2);
    #1; check("hit_spk_t2", int'(speaker), 1);
    idle_cycles(28);
    #1;
    check("hit_gap_busy", int'(busy), 1);
    check("hit_gap_id", int'(active_id), 0);
    check("hit_gap_spk", int'(speaker), 0);
    idle_cycles(20);
    #1; check("hit_done_busy", int'(busy), 0);
    wait_idle();

    // All three at once: over plays 80 then gap, hit/miss dropped.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    #1; check("all_id", int'(active_id), 3);
    idle_cycles(80);
    #1; check("all_gap_id", int'(active_id), 0);
    idle_cycles(20);
    #1; check("all_done_busy", int'(busy), 0);
    idle_cycles(1);
    #1; check("all_no_replay", int'(busy), 0);
    wait_idle();

    // Miss during hit waits for hit + gap, then plays with period 3.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(10);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(19);
    #1; check("mh_gap_id", int'(active_id), 0);
    idle_cycles(20);
    #1; check("mh_idle_busy", int'(busy), 0);
    idle_cycles(1);
    #1; check("mh_miss_id", int'(active_id), 2);
    idle_cycles(3);
    #1; check("mh_miss_spk_t3", int'(speaker), 1);
    wait_idle();

    // Over at cycle 10 of a miss tone preempts; miss not replayed.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(10);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("pre_id", int'(active_id), 3);
    check("pre_spk", int'(speaker), 0);
    idle_cycles(101);
    #1;
    check("pre_no_miss_busy", int'(busy), 0);
    check("pre_no_miss_id", int'(active_id), 0);
    wait_idle();

    // Two hits 5 apart: second replays after the gap.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(45);
    #1; check("hh_idle_busy", int'(busy), 0);
    idle_cycles(1);
    #1; check("hh_replay_id", int'(active_id), 1);
    wait_idle();

    // Mute during a hit tone.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("mute_spk", int'(speaker), 0);
    check("mute_id", int'(active_id), 1);
    wait_idle();

    // Reset mid-tone clears outputs at once; nothing follows release.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    @(negedge clk);
    #1; check("rst_pre_spk", int'(speaker), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_spk", int'(speaker), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_id", int'(active_id), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    idle_cycles(10);
    #1; check("rst_after_busy", int'(busy), 0);

    // Random requests and mute.
    begin
      bit mu;
      mu = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 24) == 0) mu = ~mu;
        cycle($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 199) == 0, mu);
      end
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Arbitrates game sound requests (paddle hit, ball miss, game over) onto the single board speaker pin.
- Queues one pending request per source and grants by fixed priority.
- Plays each granted sound as a fixed-frequency square tone for a fixed duration, followed by a silent gap.
- Sits between the top-level game FSM, which issues one-cycle request pulses, and the speaker output. It replaces per-sound tone instances and ad-hoc output muxing.

Parameters:
- TICK_DIV, 100000, clk cycles per duration tick (1 ms at 100 MHz).
- HIT_MS, 50, hit tone duration in ticks.
- MISS_MS, 300, miss tone duration in ticks.
- OVER_MS, 1000, game-over tone duration in ticks.
- GAP_MS, 20, silent gap after every tone, in ticks.
- HIT_HALF, 50000, hit tone half-period in clk cycles (1 kHz).
- MISS_HALF, 200000, miss tone half-period in clk cycles (250 Hz).
- OVER_HALF, 250000, game-over tone half-period in clk cycles (200 Hz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- hit_req  in  1  one-cycle pulse: paddle hit, either player.
- miss_req  in  1  one-cycle pulse: ball missed.
- over_req  in  1  one-cycle pulse: game over.
- mute  in  1  level; silences the speaker without stopping sequencing.
- speaker  out  1  square-wave output to the speaker pin, registered.
- busy  out  1  high in PLAY or GAP.
- active_id  out  2  00 none, 01 hit, 10 miss, 11 over.

Behaviour:
- Reset: asynchronous, active-high, clock clk. Every register clears.
  - State IDLE; all pending flags 0.
  - speaker=0, busy=0, active_id=00.
  - Prescaler, duration counter and half-period counter all 0.
  - Reset mid-tone aborts the tone immediately; nothing resumes after release.
- Pending flags (one per source):
  - A flag sets on its request pulse.
  - It clears on the edge that grants that source.
  - A request for a source already pending coalesces into the existing flag (no counting).
  - A request for the source currently playing sets its flag again, so it replays after the gap.
- Arbitration:
  - Effective request for each source = pending OR req.
  - Priority: over > miss > hit.
- State machine IDLE / PLAY / GAP:
  - IDLE: if any effective request is present, grant the highest one on this edge.
    - State goes to PLAY.
    - active_id is loaded with the granted source.
    - Duration counter is loaded with that source's *_MS value.
    - Prescaler and half counter clear; speaker is 0.
    - Latency: a pulse in cycle k gives busy=1 and active_id valid in cycle k+1.
  - PLAY:
    - Prescaler counts 0..TICK_DIV-1 and wraps.
    - At the wrap, the duration counter decrements.
    - When the counter is at 1 and wraps, the next state is GAP, with the duration counter loaded with GAP_MS.
    - Tone length is exactly DUR_MS*TICK_DIV cycles.
  - GAP:
    - speaker forced to 0; active_id=00; busy=1.
    - Counts GAP_MS ticks the same way, then goes to IDLE.
    - IDLE grants a pending request on the following edge.
- Tone generation in PLAY:
  - The half counter counts 0..HALF-1 for the active source.
  - speaker toggles when the half counter wraps.
  - The first toggle comes HALF cycles after the grant.
- Preemption:
  - over_req (pulse, or its pending flag) while PLAY is on hit or miss aborts that tone on the next edge.
  - It is granted directly: PLAY(over) with fresh counters, no gap.
  - The over grant also clears the hit and miss pending flags, since the rally ends.
  - Miss does not preempt hit; it waits.
- Simultaneous pulses in one cycle:
  - All flags set.
  - The highest priority is granted; the others remain pending, subject to the over-clears rule above.
- Mute:
  - speaker output = internal tone AND NOT mute, applied combinationally after the register.
  - All counters and states advance unchanged while muted.
- Widths:
  - Half counter 18 bits.
  - Prescaler 17 bits.
  - Duration counter 10 bits; *_MS ≤ 1023 is checked by an elaboration-time assertion.

Decomposition:
- Shared package sound_pkg holds:
  - Source ID localparams: SND_NONE=0, SND_HIT=1, SND_MISS=2, SND_OVER=3.
  - State encoding: IDLE=0, PLAY=1, GAP=2.
- Sub-module tone_gen is natural and contains the half counter and toggle flop.
  - Inputs: clk, reset, en, clr, half[17:0].
  - Output: wave.
  - sound_sequencer drives half from active_id and clr on grant.

Test Plan (bench parameters TICK_DIV=10, HIT_MS=3, MISS_MS=5, OVER_MS=8, GAP_MS=2, HIT_HALF=2, MISS_HALF=3, OVER_HALF=4):
- Single hit_req pulse at cycle 0:
  - Cycle 1: busy=1, active_id=01.
  - speaker toggles every 2 cycles for 30 cycles.
  - Then 20 cycles of GAP with speaker=0, active_id=00.
  - Then busy=0.
- hit_req, miss_req and over_req in the same cycle:
  - over plays 80 cycles, then GAP, then IDLE with busy=0.
  - Hit and miss flags are cleared by the over grant.
- miss_req during a hit tone:
  - Hit completes its full 30 cycles, then 20 cycles of gap.
  - Miss is then granted (active_id=10) and plays 50 cycles with a toggle every 3 cycles.
- over_req at cycle 10 of a miss tone:
  - Cycle 11: active_id=11, with the half counter and duration counter restarted.
  - Miss is not replayed afterwards.
- Two hit_req pulses 5 cycles apart while idle:
  - First hit plays; second coalesces and replays after the gap.
  - Total: exactly two hit tones, separated by 20 silent cycles.
- Assert mute during a hit tone:
  - speaker=0 immediately while muted.
  - Timing and active_id are unaffected.
- Assert reset mid-tone:
  - Outputs are 0 asynchronously.
  - No tone follows release without a new request.
